toggle_monitor: RTL

TOGGLE_MONITOR -- requirements
Module: toggle_monitor

---
 rtl/toggle_monitor_pkg.sv | 13 +
 rtl/toggle_sat_counter.sv | 31 +++
 rtl/toggle_monitor.sv | 129 ++++++++++++
 3 files changed

// File: rtl/toggle_monitor_pkg.sv
// rtl/toggle_monitor_pkg.sv - shared state encoding and default widths for toggle_monitor
package toggle_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_REPORT  = 2'd2
    } state_t;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_WIN_W = 16;

endpackage

// File: rtl/toggle_sat_counter.sv
// rtl/toggle_sat_counter.sv - clearable up-counter that clamps at all-ones
module toggle_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_value,
    output logic             o_sat
);

    logic [CNT_W-1:0] r_value;
    logic             w_at_max;

    assign w_at_max = &r_value;
    // Flags an increment that was swallowed because the counter is already full.
    assign o_sat    = i_inc & w_at_max;
    assign o_value  = r_value;

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_value <= '0;
        end else if (i_clear) begin
            r_value <= '0;
        end else if (i_inc && !w_at_max) begin
            r_value <= r_value + CNT_W'(1);
        end
    end

endmodule

// File: rtl/toggle_monitor.sv
// rtl/toggle_monitor.sv - windowed rise/fall/high counter for a cell output; TOGGLE_MONITOR_SYNC_EN adds a 2-flop input synchronizer
module toggle_monitor
    import toggle_monitor_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int WIN_W = DEF_WIN_W
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic             START,
    input  logic [WIN_W-1:0] WIN_LEN,
    input  logic             QN_IN,
    input  logic             RES_READY,
    output logic             BUSY,
    output logic             RES_VALID,
    output logic [CNT_W-1:0] RISE_CNT,
    output logic [CNT_W-1:0] FALL_CNT,
    output logic [CNT_W-1:0] HIGH_CNT,
    output logic             SAT
);

    state_t           r_state;
    state_t           w_next;
    logic [WIN_W-1:0] r_remain;
    logic             r_first;
    logic             r_prev;
    logic             r_sat;
    logic             w_qn;
    logic             w_start_ok;
    logic             w_sample;
    logic             w_last;
    logic             w_clear;
    logic             w_rise_inc;
    logic             w_fall_inc;
    logic             w_high_inc;
    logic             w_rise_sat;
    logic             w_fall_sat;
    logic             w_high_sat;

`ifdef TOGGLE_MONITOR_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], QN_IN};
        end
    end

    assign w_qn = r_sync[1];
`else
    assign w_qn = QN_IN;
`endif

    assign w_start_ok = START && (WIN_LEN != '0);
    assign w_sample   = (r_state == ST_MEASURE);
    assign w_last     = w_sample && (r_remain == WIN_W'(1));
    assign w_clear    = (r_state == ST_IDLE) && w_start_ok;

    // The first sample of a window only establishes the baseline level.
    assign w_rise_inc = w_sample && !r_first && !r_prev &&  w_qn;
    assign w_fall_inc = w_sample && !r_first &&  r_prev && !w_qn;
    assign w_high_inc = w_sample && w_qn;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_start_ok) w_next = ST_MEASURE;
            ST_MEASURE: if (w_last)     w_next = ST_REPORT;
            ST_REPORT:  if (RES_READY)  w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            r_state  <= ST_IDLE;
            r_remain <= '0;
            r_first  <= 1'b0;
            r_prev   <= 1'b0;
            r_sat    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_clear) begin
                r_remain <= WIN_LEN;
                r_first  <= 1'b1;
                r_sat    <= 1'b0;
            end else if (w_sample) begin
                r_remain <= r_remain - WIN_W'(1);
                r_first  <= 1'b0;
                r_prev   <= w_qn;
                r_sat    <= r_sat | w_rise_sat | w_fall_sat | w_high_sat;
            end
        end
    end

    toggle_sat_counter #(.CNT_W(CNT_W)) u_rise_cnt (
        .i_clk    (CLK),
        .i_resetn (RSTB),
        .i_clear  (w_clear),
        .i_inc    (w_rise_inc),
        .o_value  (RISE_CNT),
        .o_sat    (w_rise_sat)
    );

    toggle_sat_counter #(.CNT_W(CNT_W)) u_fall_cnt (
        .i_clk    (CLK),
        .i_resetn (RSTB),
        .i_clear  (w_clear),
        .i_inc    (w_fall_inc),
        .o_value  (FALL_CNT),
        .o_sat    (w_fall_sat)
    );

    toggle_sat_counter #(.CNT_W(CNT_W)) u_high_cnt (
        .i_clk    (CLK),
        .i_resetn (RSTB),
        .i_clear  (w_clear),
        .i_inc    (w_high_inc),
        .o_value  (HIGH_CNT),
        .o_sat    (w_high_sat)
    );

    assign BUSY      = (r_state != ST_IDLE);
    assign RES_VALID = (r_state == ST_REPORT);
    assign SAT       = r_sat;

endmodule
